// File: rtl/tama_pkg.sv
// Shared types and constants for the pet stats telemetry path.
package tama_pkg;
    localparam int STAT_W = 5;
    localparam int FRAME_LEN = 9;
    localparam logic [7:0] HEADER_DEF = 8'hA5;

    // One state per frame byte, plus IDLE.
    typedef enum logic [$clog2(FRAME_LEN+1)-1:0] {
        IDLE, HDR, SEQ, ST0, ST1, ST2, ST3, ST4, FLAGS, CSUM
    } state_t;

    typedef struct packed {
        logic [STAT_W-1:0] hunger;
        logic [STAT_W-1:0] happiness;
        logic [STAT_W-1:0] hygiene;
        logic [STAT_W-1:0] energy;
        logic [STAT_W-1:0] social;
        logic              sleeping;
    } snap_t;

    function automatic logic [7:0] stat_byte(input logic [STAT_W-1:0] s);
        return {{(8-STAT_W){1'b0}}, s};
    endfunction
endpackage

// File: rtl/stats_reporter_if.sv
// Byte-wide valid/ready link from the reporter to the UART transmitter.
interface stats_reporter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/frame_checksum.sv
// Running modulo-256 sum of the frame bytes that follow the header.
module frame_checksum (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] data,
    output logic [7:0] sum
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       sum <= 8'h00;
        else if (clr)    sum <= 8'h00;
        else if (add_en) sum <= sum + data;
    end
endmodule

// File: rtl/stats_reporter.sv
// Snapshots the pet stats periodically or on demand and streams them as a
// 9-byte telemetry frame over a valid/ready byte link.
module stats_reporter
    import tama_pkg::*;
#(
    parameter logic [7:0]        REPORT_PERIOD = 8'd5,
    parameter logic [STAT_W-1:0] CRIT_LEVEL    = 5'd4,
    parameter logic [7:0]        HEADER        = HEADER_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              second,
    input  logic              force_req,
    input  logic [STAT_W-1:0] hunger,
    input  logic [STAT_W-1:0] happiness,
    input  logic [STAT_W-1:0] hygiene,
    input  logic [STAT_W-1:0] energy,
    input  logic [STAT_W-1:0] social,
    input  logic              is_sleeping,
    stats_reporter_if.master  tx,
    output logic              busy,
    output logic [7:0]        drop_count
);
    state_t     state, state_nxt;
    snap_t      snap;
    logic [7:0] period_cnt, seq, tx_byte, csum, flags;
    logic       pending, trigger, req, accept, frame_end, start, csum_add;

    assign trigger   = second && (period_cnt == REPORT_PERIOD - 8'd1);
    assign req       = trigger | force_req;
    assign busy      = (state != IDLE);
    assign accept    = busy && tx.tx_ready;
    assign frame_end = (state == CSUM) && accept;
    // A queued or coincident request chains straight into the next frame.
    assign start     = ((state == IDLE) && req) || (frame_end && (pending || req));
    assign csum_add  = accept && (state inside {SEQ, ST0, ST1, ST2, ST3, ST4, FLAGS});

    assign flags = {snap.sleeping, 2'b00,
                    snap.social    < CRIT_LEVEL,
                    snap.energy    < CRIT_LEVEL,
                    snap.hygiene   < CRIT_LEVEL,
                    snap.happiness < CRIT_LEVEL,
                    snap.hunger    < CRIT_LEVEL};

    assign tx.tx_valid = busy;
    assign tx.tx_data  = tx_byte;

    frame_checksum u_csum (
        .clk    (clk),
        .reset  (reset),
        .clr    (start),
        .add_en (csum_add),
        .data   (tx_byte),
        .sum    (csum)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req)    state_nxt = HDR;
            HDR:     if (accept) state_nxt = SEQ;
            SEQ:     if (accept) state_nxt = ST0;
            ST0:     if (accept) state_nxt = ST1;
            ST1:     if (accept) state_nxt = ST2;
            ST2:     if (accept) state_nxt = ST3;
            ST3:     if (accept) state_nxt = ST4;
            ST4:     if (accept) state_nxt = FLAGS;
            FLAGS:   if (accept) state_nxt = CSUM;
            CSUM:    if (accept) state_nxt = (pending || req) ? HDR : IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            HDR:     tx_byte = HEADER;
            SEQ:     tx_byte = seq;
            ST0:     tx_byte = stat_byte(snap.hunger);
            ST1:     tx_byte = stat_byte(snap.happiness);
            ST2:     tx_byte = stat_byte(snap.hygiene);
            ST3:     tx_byte = stat_byte(snap.energy);
            ST4:     tx_byte = stat_byte(snap.social);
            FLAGS:   tx_byte = flags;
            CSUM:    tx_byte = csum;
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            snap       <= '0;
            period_cnt <= 8'h00;
            seq        <= 8'h00;
            pending    <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            state <= state_nxt;
            if (second) period_cnt <= trigger ? 8'h00 : period_cnt + 8'd1;
            if (start)
                snap <= {hunger, happiness, hygiene, energy, social, is_sleeping};
            if (frame_end) seq <= seq + 8'd1;
            // At frame end a new request replaces the pending one being consumed.
            if (frame_end)
                pending <= pending && req;
            else if (busy && req) begin
                if (!pending)                 pending    <= 1'b1;
                else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end
endmodule
